// File: rtl/registro_arbitro_rr.sv
// ---------------------------------------------------------------------------
// registro_arbitro_rr
//
// Four requesters compete to write one shared W-bit register. A round-robin
// arbiter selects one winner, and the block loads that winner's data into the
// register and pulses its ack bit for one cycle. The register is then held
// for HOLD_CYCLES cycles before the next arbitration.
//
// Parameters
//   W            data width of each requester and of the shared register
//   HOLD_CYCLES  cycles spent in HOLD after each load (legal range 1..255)
//
// Ports
//   clk        system clock, rising edge
//   rst        synchronous, active-high reset
//   req[3:0]   request vector, bit i = requester i wants to write
//   din        packed data, requester i occupies din[i*W +: W]
//   ack[3:0]   one-hot, one-cycle pulse: requester i was loaded
//   q          shared register contents
//   q_valid    high once q holds any loaded value
//   owner      index of the requester whose data is in q
//   busy       high while in HOLD
//   dbg_state  current FSM state (0 = IDLE, 1 = HOLD), for observation only
//
// Handshake: a requester raises req[i] with din[i] stable and keeps both
// stable until it sees ack[i]. The load and the ack happen on the same edge,
// so ack[i] is both "data taken" and "request consumed". A req bit still high
// in the cycle after its ack counts as a fresh request. A req bit dropped
// before its ack is simply forgotten. din of a non-winner is never used.
// ---------------------------------------------------------------------------
module registro_arbitro_rr #(
   parameter int W           = 8,
   parameter int HOLD_CYCLES = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [3:0]     req,
   input  logic [4*W-1:0] din,
   output logic [3:0]     ack,
   output logic [W-1:0]   q,
   output logic           q_valid,
   output logic [1:0]     owner,
   output logic           busy,
   output logic           dbg_state
);

   localparam int N = 4;

   // The counter is reloaded with HOLD_CYCLES-1 on each grant. It then counts
   // down to zero, and the HOLD state is left on the edge where it reads zero.
   localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_HOLD = 1'b1
   } state_t;

   state_t         state;
   logic [1:0]     rr_ptr;     // highest-priority index for the next grant
   logic [7:0]     hold_cnt;

   // Arbitration datapath (combinational, used only in IDLE)
   logic [2*N-1:0] req_dbl;
   logic [N-1:0]   req_rot;    // req rotated so that bit 0 is rr_ptr
   logic [1:0]     win_off;
   logic [1:0]     win_idx;
   logic [N-1:0]   win_onehot;
   logic [W-1:0]   win_data;
   logic           any_req;

   always_comb begin
      req_dbl    = {req, req} >> rr_ptr;
      req_rot    = req_dbl[N-1:0];
      any_req    = |req;
      // The lowest set bit of the rotated vector is the first requester at
      // or after rr_ptr in priority order. Scanning downward lets the last
      // assignment win.
      win_off    = '0;
      for (int i = N - 1; i >= 0; i--) begin
         if (req_rot[i]) begin
            win_off = 2'(i);
         end
      end
      // The 2-bit addition wraps modulo 4, which undoes the rotation.
      win_idx    = rr_ptr + win_off;
      win_onehot = N'(1) << win_idx;
      win_data   = din[int'(win_idx) * W +: W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_IDLE;
         rr_ptr   <= '0;
         hold_cnt <= '0;
         q        <= '0;
         q_valid  <= 1'b0;
         owner    <= '0;
         ack      <= '0;
         busy     <= 1'b0;
      end else begin
         // ack is a pulse: it is cleared every cycle unless a grant re-raises it.
         ack <= '0;
         case (state)
            S_IDLE: begin
               if (any_req) begin
                  q        <= win_data;
                  owner    <= win_idx;
                  q_valid  <= 1'b1;
                  ack      <= win_onehot;
                  rr_ptr   <= win_idx + 2'd1;
                  hold_cnt <= HOLD_RELOAD;
                  busy     <= 1'b1;
                  state    <= S_HOLD;
               end
            end
            S_HOLD: begin
               // req is ignored for the whole HOLD window.
               if (hold_cnt != 8'd0) begin
                  hold_cnt <= hold_cnt - 8'd1;
               end else begin
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   assign dbg_state = state;

   // Structural properties of the grant pulse
   a_ack_onehot : assert property (@(posedge clk) disable iff (rst)
      $onehot0(ack));
   a_ack_busy   : assert property (@(posedge clk) disable iff (rst)
      (|ack) |-> busy);
   a_ack_pulse  : assert property (@(posedge clk) disable iff (rst)
      (|ack) |=> (ack == '0));

endmodule

// File: tb/tb_registro_arbitro_rr.sv
// ---------------------------------------------------------------------------
// tb_registro_arbitro_rr
//
// Bench for registro_arbitro_rr with W=8 and HOLD_CYCLES=2. It runs a
// vector table, hand-written corner sequences, and then random traffic.
// Every cycle is compared against a behavioural model of the arbiter.
// ---------------------------------------------------------------------------
module tb_registro_arbitro_rr;

   localparam int W    = 8;
   localparam int HOLD = 2;

   // Clock and reset
   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  req;
   logic [31:0] din;
   logic [3:0]  ack;
   logic [7:0]  q;
   logic        q_valid;
   logic [1:0]  owner;
   logic        busy;
   logic        dbg_state;

   always #5 clk = ~clk;

   registro_arbitro_rr #(.W(W), .HOLD_CYCLES(HOLD)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .din       (din),
      .ack       (ack),
      .q         (q),
      .q_valid   (q_valid),
      .owner     (owner),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   // Scoreboard counters
   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
      end
   endtask

   // Behavioural model. hold_left counts the remaining HOLD edges, and busy
   // is simply "hold edges remain".
   logic [3:0] m_ack;
   logic [7:0] m_q;
   logic       m_valid;
   logic [1:0] m_owner;
   int         m_ptr;
   int         m_hold_left;

   task automatic model_edge(input logic r, input logic [3:0] rq, input logic [31:0] d);
      int w;
      m_ack = '0;
      if (r) begin
         m_q = '0; m_valid = 1'b0; m_owner = '0; m_ptr = 0; m_hold_left = 0;
      end else if (m_hold_left > 0) begin
         m_hold_left--;
      end else if (rq != 0) begin
         w = -1;
         for (int off = 0; off < 4; off++) begin
            if (w < 0 && rq[(m_ptr + off) % 4]) w = (m_ptr + off) % 4;
         end
         m_q         = d[w*8 +: 8];
         m_owner     = 2'(w);
         m_valid     = 1'b1;
         m_ack       = 4'(1 << w);
         m_ptr       = (w + 1) % 4;
         m_hold_left = HOLD;
      end
   endtask

   function automatic logic [15:0] dut_vec();
      return {ack, q, q_valid, owner, busy};
   endfunction

   function automatic logic [15:0] model_vec();
      return {m_ack, m_q, m_valid, m_owner, logic'(m_hold_left != 0)};
   endfunction

   // Driver: apply inputs, cross one rising edge, compare against the model.
   task automatic step(input logic r, input logic [3:0] rq, input logic [31:0] d, input string name);
      rst = r; req = rq; din = d;
      model_edge(r, rq, d);
      @(posedge clk);
      #1;
      chk({name, "/model"}, {16'h0, dut_vec()}, {16'h0, model_vec()});
   endtask

   // Vector table
   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [31:0] din;
      logic [3:0]  ack;
      logic [7:0]  q;
      logic        v;
      logic [1:0]  own;
      logic        busy;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d,
                      input logic [3:0] a, input logic [7:0] qq, input logic v,
                      input logic [1:0] o, input logic b);
      vec_t e;
      e.rst = r; e.req = rq; e.din = d; e.ack = a; e.q = qq; e.v = v; e.own = o; e.busy = b;
      tbl.push_back(e);
   endtask

   logic [7:0] seen_q;
   logic [7:0] rr_q;

   initial begin
      rst = 1'b1; req = '0; din = '0;
      m_ack = '0; m_q = '0; m_valid = 1'b0; m_owner = '0; m_ptr = 0; m_hold_left = 0;

      // Reset (req/din are randomized at apply time), then a single requester
      add(1, 4'b0000, 32'h0, 4'b0000, 8'h00, 0, 0, 0);
      add(1, 4'b0000, 32'h0, 4'b0000, 8'h00, 0, 0, 0);
      add(0, 4'b0100, 32'h00A5_0000, 4'b0100, 8'hA5, 1, 2, 1);
      add(0, 4'b0000, 32'h0, 4'b0000, 8'hA5, 1, 2, 1);
      add(0, 4'b0000, 32'h0, 4'b0000, 8'hA5, 1, 2, 0);
      add(1, 4'b0000, 32'h0, 4'b0000, 8'h00, 0, 0, 0);
      // Round-robin with all four requesting: one grant every HOLD+1 cycles
      for (int g = 0; g < 5; g++) begin
         rr_q = 8'h10 + 8'(g % 4);
         add(0, 4'b1111, 32'h1312_1110, 4'(1 << (g % 4)), rr_q, 1, 2'(g % 4), 1);
         if (g < 4) begin
            add(0, 4'b1111, 32'h1312_1110, 4'b0000, rr_q, 1, 2'(g % 4), 1);
            add(0, 4'b1111, 32'h1312_1110, 4'b0000, rr_q, 1, 2'(g % 4), 0);
         end
      end

      foreach (tbl[i]) begin
         logic [3:0]  rq;
         logic [31:0] d;
         rq = tbl[i].req;
         d  = tbl[i].din;
         if (tbl[i].rst) begin
            rq = 4'($urandom);
            d  = $urandom;
         end
         step(tbl[i].rst, rq, d, $sformatf("tbl%0d", i));
         chk($sformatf("tbl%0d", i), {16'h0, dut_vec()},
             {16'h0, tbl[i].ack, tbl[i].q, tbl[i].v, tbl[i].own, tbl[i].busy});
      end

      // Reset in the middle of HOLD
      step(1, 4'b0000, 32'h0, "rst_clean");
      step(0, 4'b0010, 32'h0000_3C00, "rst_mid_grant");
      chk("rst_mid_grant_ack", {28'h0, ack}, 32'h2);
      chk("rst_mid_grant_q", {24'h0, q}, 32'h3C);
      step(1, 4'b0010, 32'h0000_3C00, "rst_mid");
      chk("rst_mid_q", {24'h0, q}, 32'h0);
      chk("rst_mid_flags", {28'h0, q_valid, busy, dbg_state, |ack}, 32'h0);
      step(0, 4'b0011, 32'h0000_2211, "rst_ptr0");
      chk("rst_ptr0_ack", {28'h0, ack}, 32'h1);

      // Pointer rotation
      step(0, 4'b0000, 32'h0, "rot_hold1");
      step(0, 4'b0000, 32'h0, "rot_hold2");
      step(0, 4'b1000, 32'h4400_0000, "rot_g3");
      chk("rot_g3_ack", {28'h0, ack}, 32'h8);
      step(0, 4'b1001, 32'h4400_0055, "rot_ign1");
      chk("rot_ign1_ack", {28'h0, ack}, 32'h0);
      step(0, 4'b1001, 32'h4400_0055, "rot_ign2");
      step(0, 4'b1001, 32'h4400_0055, "rot_g0");
      chk("rot_g0_ack", {28'h0, ack}, 32'h1);
      chk("rot_g0_q", {24'h0, q}, 32'h55);
      step(0, 4'b1001, 32'h4400_0055, "rot_h1");
      step(0, 4'b1001, 32'h4400_0055, "rot_h2");
      step(0, 4'b1001, 32'h4400_0055, "rot_g3b");
      chk("rot_g3b_ack", {28'h0, ack}, 32'h8);
      chk("rot_g3b_owner", {30'h0, owner}, 32'h3);

      // Request raised and dropped while in HOLD
      step(0, 4'b0000, 32'h0, "drop_h1");
      step(0, 4'b0000, 32'h0, "drop_h2");
      step(0, 4'b0001, 32'h0000_0077, "drop_g0");
      chk("drop_g0_q", {24'h0, q}, 32'h77);
      step(0, 4'b0010, 32'h0000_9900, "drop_raise");
      chk("drop_raise_busy", {31'h0, busy}, 32'h1);
      step(0, 4'b0000, 32'h0, "drop_low");
      chk("drop_busy_sched", {31'h0, busy}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         step(0, 4'b0000, 32'h0, "drop_idle");
         chk("drop_no_ack", {28'h0, ack}, 32'h0);
         chk("drop_q_kept", {24'h0, q}, 32'h77);
      end

      // Random traffic against the model
      seen_q = 8'h0;
      for (int i = 0; i < 400; i++) begin
         logic        r;
         logic [3:0]  rq;
         r  = ($urandom_range(0, 49) == 0);
         rq = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
         step(r, rq, $urandom, $sformatf("rand%0d", i));
         if (|ack) seen_q = seen_q + 8'd1;
      end
      chk("rand_grants_seen", {31'h0, logic'(seen_q > 8'd20)}, 32'h1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
